// File: rtl/warp_pkg.sv
// Shared types and defaults for the multi-warp dispatcher.
package warp_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} warp_ctx_state_e;
  localparam int NUM_WARPS_DEFAULT = 4;
  localparam int BUF_DEPTH_DEFAULT = 4;
endpackage

// File: rtl/multi_warp_dispatcher_rr_arbiter.sv
// Round-robin arbiter; pointer moves past the winner on advance.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] ptr_q, ptr_d, idx, gidx;
  logic found;

  always_comb begin
    grant = '0;
    gidx  = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = ptr_q + IW'(i);
      if (!found && req[idx]) begin
        found     = 1'b1;
        grant[idx] = 1'b1;
        gidx      = idx;
      end
    end
    ptr_d = ptr_q;
    if (advance && found) ptr_d = gidx + IW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
endmodule

// File: rtl/multi_warp_dispatcher.sv
// Per-warp fetch/buffer/issue dispatcher. Optional counters: WARP_DISPATCH_STATS_EN.
module multi_warp_dispatcher
  import warp_pkg::*;
#(
  parameter int NUM_WARPS  = NUM_WARPS_DEFAULT,
  parameter int NUM_LANES  = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int BUF_DEPTH  = BUF_DEPTH_DEFAULT,
  parameter int LEN_WIDTH  = 16,
  localparam int WID = $clog2(NUM_WARPS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  launch_valid,
  output logic                  launch_ready,
  input  logic [WID-1:0]        launch_warp,
  input  logic [ADDR_WIDTH-1:0] launch_addr,
  input  logic [LEN_WIDTH-1:0]  launch_len,
  input  logic [NUM_LANES-1:0]  launch_mask,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [WID-1:0]        mem_req_tag,
  input  logic                  mem_resp_valid,
  input  logic [WID-1:0]        mem_resp_tag,
  input  logic [31:0]           mem_resp_data,
  output logic                  issue_valid,
  input  logic                  issue_ready,
  output logic [WID-1:0]        issue_warp,
  output logic [31:0]           issue_instr,
  output logic [NUM_LANES-1:0]  issue_mask,
  output logic                  done_valid,
  output logic [WID-1:0]        done_warp,
  output logic                  launch_error,
  output logic [NUM_WARPS-1:0]  warp_busy
`ifdef WARP_DISPATCH_STATS_EN
  ,
  output logic [31:0]           stat_issued,
  output logic [31:0]           stat_stall
`endif
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;

  warp_ctx_state_e       state_q [NUM_WARPS];
  warp_ctx_state_e       state_d [NUM_WARPS];
  logic [ADDR_WIDTH-1:0] addr_q  [NUM_WARPS];
  logic [ADDR_WIDTH-1:0] addr_d  [NUM_WARPS];
  logic [LEN_WIDTH-1:0]  rem_q   [NUM_WARPS];
  logic [LEN_WIDTH-1:0]  rem_d   [NUM_WARPS];
  logic [LEN_WIDTH-1:0]  left_q  [NUM_WARPS];
  logic [LEN_WIDTH-1:0]  left_d  [NUM_WARPS];
  logic [NUM_LANES-1:0]  mask_q  [NUM_WARPS];
  logic [NUM_LANES-1:0]  mask_d  [NUM_WARPS];
  logic [CW-1:0]         occ_q   [NUM_WARPS];
  logic [CW-1:0]         occ_d   [NUM_WARPS];
  logic [CW-1:0]         outs_q  [NUM_WARPS];
  logic [CW-1:0]         outs_d  [NUM_WARPS];
  logic [CW-1:0]         wp_q    [NUM_WARPS];
  logic [CW-1:0]         wp_d    [NUM_WARPS];
  logic [CW-1:0]         rp_q    [NUM_WARPS];
  logic [CW-1:0]         rp_d    [NUM_WARPS];
  logic [31:0]           mem_q   [NUM_WARPS][BUF_DEPTH];

  logic [NUM_WARPS-1:0] idle, buf_ne, fetch_elig, fetch_req;
  logic [NUM_WARPS-1:0] fetch_gnt, issue_gnt;
  logic [NUM_WARPS-1:0] fire_v, push_v, pop_v, ack_v;
  logic [WID-1:0]       fetch_idx, issue_idx;
  logic                 hold_q, hold_d;
  logic [WID-1:0]       hold_tag_q, hold_tag_d;
  logic                 err_q, err_d;
  logic                 launch_hs, launch_ok, req_fire, resp_ok;
  logic                 issue_fire, issue_load;

  logic                 issue_valid_q, issue_valid_d;
  logic [WID-1:0]       issue_warp_q, issue_warp_d;
  logic [31:0]          issue_instr_q, issue_instr_d;
  logic [NUM_LANES-1:0] issue_mask_q, issue_mask_d;

  // Credit counts the held issue slot too, so occupancy only drops on handshake
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      idle[w]       = (state_q[w] == IDLE);
      buf_ne[w]     = (wp_q[w] != rp_q[w]);
      fetch_elig[w] = (state_q[w] == FETCH) &&
                      (({1'b0, occ_q[w]} + {1'b0, outs_q[w]}) <
                       (CW+1)'(BUF_DEPTH));
    end
  end

  // A stalled request pins the arbiter to the same warp
  assign fetch_req = hold_q ? (NUM_WARPS'(1) << hold_tag_q) : fetch_elig;

  rr_arbiter #(.N(NUM_WARPS)) u_fetch_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (fetch_req),
    .advance (req_fire),
    .grant   (fetch_gnt)
  );

  rr_arbiter #(.N(NUM_WARPS)) u_issue_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (buf_ne),
    .advance (issue_load),
    .grant   (issue_gnt)
  );

  always_comb begin
    fetch_idx = '0;
    issue_idx = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (fetch_gnt[w]) fetch_idx = WID'(w);
      if (issue_gnt[w]) issue_idx = WID'(w);
    end
  end

  assign mem_req_valid = |fetch_gnt;
  assign mem_req_tag   = fetch_idx;
  assign mem_req_addr  = addr_q[fetch_idx];
  assign req_fire      = mem_req_valid && mem_req_ready;
  assign hold_d        = mem_req_valid && !mem_req_ready;
  assign hold_tag_d    = fetch_idx;

  assign resp_ok    = mem_resp_valid && (outs_q[mem_resp_tag] != '0);
  assign issue_fire = issue_valid_q && issue_ready;
  assign issue_load = (!issue_valid_q || issue_ready) && (|buf_ne);

  assign launch_ready = !rst && (|idle);
  assign launch_hs    = launch_valid && launch_ready;
  assign launch_ok    = launch_hs && idle[launch_warp] &&
                        (launch_len != '0);
  assign err_d        = launch_hs && !launch_ok;

  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      fire_v[w] = req_fire && fetch_gnt[w];
      push_v[w] = resp_ok && (mem_resp_tag == WID'(w));
      pop_v[w]  = issue_load && issue_gnt[w];
      ack_v[w]  = issue_fire && (issue_warp_q == WID'(w));
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    left_d  = left_q;
    mask_d  = mask_q;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (launch_ok && launch_warp == WID'(w)) begin
        state_d[w] = FETCH;
        addr_d[w]  = launch_addr;
        rem_d[w]   = launch_len;
        left_d[w]  = launch_len;
        mask_d[w]  = launch_mask;
      end
      if (fire_v[w]) begin
        addr_d[w] = addr_q[w] + ADDR_WIDTH'(4);
        rem_d[w]  = rem_q[w] - LEN_WIDTH'(1);
        if (rem_q[w] == LEN_WIDTH'(1)) state_d[w] = DRAIN;
      end
      if (ack_v[w]) begin
        left_d[w] = left_q[w] - LEN_WIDTH'(1);
        if (left_q[w] == LEN_WIDTH'(1)) state_d[w] = IDLE;
      end
      outs_d[w] = outs_q[w] + CW'(fire_v[w]) - CW'(push_v[w]);
      occ_d[w]  = occ_q[w] + CW'(push_v[w]) - CW'(ack_v[w]);
      wp_d[w]   = wp_q[w] + CW'(push_v[w]);
      rp_d[w]   = rp_q[w] + CW'(pop_v[w]);
    end
  end

  always_comb begin
    issue_valid_d = issue_valid_q;
    issue_warp_d  = issue_warp_q;
    issue_instr_d = issue_instr_q;
    issue_mask_d  = issue_mask_q;
    if (!issue_valid_q || issue_ready) begin
      issue_valid_d = |buf_ne;
      if (|buf_ne) begin
        issue_warp_d  = issue_idx;
        issue_instr_d = mem_q[issue_idx][rp_q[issue_idx][PW-1:0]];
        issue_mask_d  = mask_q[issue_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resp_ok)
      mem_q[mem_resp_tag][wp_q[mem_resp_tag][PW-1:0]] <= mem_resp_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        state_q[w] <= IDLE;
        addr_q[w]  <= '0;
        rem_q[w]   <= '0;
        left_q[w]  <= '0;
        mask_q[w]  <= '0;
        occ_q[w]   <= '0;
        outs_q[w]  <= '0;
        wp_q[w]    <= '0;
        rp_q[w]    <= '0;
      end
      hold_q        <= 1'b0;
      hold_tag_q    <= '0;
      err_q         <= 1'b0;
      issue_valid_q <= 1'b0;
      issue_warp_q  <= '0;
      issue_instr_q <= '0;
      issue_mask_q  <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      rem_q         <= rem_d;
      left_q        <= left_d;
      mask_q        <= mask_d;
      occ_q         <= occ_d;
      outs_q        <= outs_d;
      wp_q          <= wp_d;
      rp_q          <= rp_d;
      hold_q        <= hold_d;
      hold_tag_q    <= hold_tag_d;
      err_q         <= err_d;
      issue_valid_q <= issue_valid_d;
      issue_warp_q  <= issue_warp_d;
      issue_instr_q <= issue_instr_d;
      issue_mask_q  <= issue_mask_d;
    end
  end

  assign issue_valid  = issue_valid_q;
  assign issue_warp   = issue_warp_q;
  assign issue_instr  = issue_instr_q;
  assign issue_mask   = issue_mask_q;
  assign done_valid   = issue_fire &&
                        (left_q[issue_warp_q] == LEN_WIDTH'(1));
  assign done_warp    = issue_warp_q;
  assign launch_error = err_q;
  assign warp_busy    = ~idle;

`ifdef WARP_DISPATCH_STATS_EN
  logic [31:0] stat_issued_q, stat_issued_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_issued_d = stat_issued_q;
    stat_stall_d  = stat_stall_q;
    if (issue_fire && stat_issued_q != '1)
      stat_issued_d = stat_issued_q + 32'd1;
    if (issue_valid_q && !issue_ready && stat_stall_q != '1)
      stat_stall_d = stat_stall_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_issued_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      stat_issued_q <= stat_issued_d;
      stat_stall_q  <= stat_stall_d;
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_stall  = stat_stall_q;
`endif
endmodule

// File: tb/tb_multi_warp_dispatcher.sv
// Directed bench for multi_warp_dispatcher with a 1-cycle memory model.
module tb_multi_warp_dispatcher;
  localparam logic [31:0] K = 32'hC0DE_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        launch_valid, launch_ready;
  logic [1:0]  launch_warp;
  logic [31:0] launch_addr;
  logic [15:0] launch_len;
  logic [7:0]  launch_mask;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic [1:0]  mem_req_tag;
  logic        mem_resp_valid = 1'b0;
  logic [1:0]  mem_resp_tag = '0;
  logic [31:0] mem_resp_data = '0;
  logic        issue_valid, issue_ready;
  logic [1:0]  issue_warp;
  logic [31:0] issue_instr;
  logic [7:0]  issue_mask;
  logic        done_valid;
  logic [1:0]  done_warp;
  logic        launch_error;
  logic [3:0]  warp_busy;
`ifdef WARP_DISPATCH_STATS_EN
  logic [31:0] stat_issued, stat_stall;
`endif

  multi_warp_dispatcher dut (
    .clk            (clk),
    .rst            (rst),
    .launch_valid   (launch_valid),
    .launch_ready   (launch_ready),
    .launch_warp    (launch_warp),
    .launch_addr    (launch_addr),
    .launch_len     (launch_len),
    .launch_mask    (launch_mask),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_tag    (mem_req_tag),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_tag   (mem_resp_tag),
    .mem_resp_data  (mem_resp_data),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .issue_warp     (issue_warp),
    .issue_instr    (issue_instr),
    .issue_mask     (issue_mask),
    .done_valid     (done_valid),
    .done_warp      (done_warp),
    .launch_error   (launch_error),
    .warp_busy      (warp_busy)
`ifdef WARP_DISPATCH_STATS_EN
    ,
    .stat_issued    (stat_issued),
    .stat_stall     (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  warp;
    logic [31:0] addr;
    logic [15:0] len;
    logic [7:0]  mask;
    logic        exp_err;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vecs[5];
  int total = 0;
  int bad = 0;
  int err_cnt = 0;
  logic        mem_hold = 1'b0;
  logic [31:0] pend_a[$];
  logic [1:0]  pend_t[$];
  logic [31:0] req_log[$];
  logic [1:0]  iw_log[$];
  logic [31:0] ii_log[$];
  logic [7:0]  im_log[$];
  logic [1:0]  done_log[$];

  // Memory and monitors act on the falling edge; the test drives 1ns after rise
  always @(negedge clk) begin
    mem_resp_valid = 1'b0;
    if (!mem_hold && pend_a.size() > 0) begin
      mem_resp_valid = 1'b1;
      mem_resp_tag   = pend_t.pop_front();
      mem_resp_data  = pend_a.pop_front() ^ K;
    end
    if (!rst && mem_req_valid && mem_req_ready) begin
      pend_a.push_back(mem_req_addr);
      pend_t.push_back(mem_req_tag);
      req_log.push_back(mem_req_addr);
    end
    if (!rst && issue_valid && issue_ready) begin
      iw_log.push_back(issue_warp);
      ii_log.push_back(issue_instr);
      im_log.push_back(issue_mask);
    end
    if (!rst && done_valid) done_log.push_back(done_warp);
    if (launch_error) err_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic clear_logs();
    req_log.delete();
    iw_log.delete();
    ii_log.delete();
    im_log.delete();
    done_log.delete();
    err_cnt = 0;
  endtask

  task automatic do_launch(input logic [1:0] w, input logic [31:0] a,
                           input logic [15:0] l, input logic [7:0] m);
    launch_valid = 1'b1;
    launch_warp  = w;
    launch_addr  = a;
    launch_len   = l;
    launch_mask  = m;
    tick();
    launch_valid = 1'b0;
  endtask

  task automatic wait_done(input int n, input string nm);
    int cyc = 0;
    while (done_log.size() < n && cyc < 400) begin
      tick();
      cyc++;
    end
    chk({nm, "_timeout"}, 64'(cyc >= 400), 0);
    tick();
    tick();
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int cyc = 0;
    int ok = 0;
    clear_logs();
    issue_ready = 1'b1;
    do_launch(v.warp, v.addr, v.len, v.mask);
    while (done_log.size() == 0 && err_cnt == 0 && cyc < 300) begin
      tick();
      cyc++;
    end
    tick();
    tick();
    chk({nm, "_timeout"}, 64'(cyc >= 300), 0);
    chk({nm, "_err"}, 64'(err_cnt), 64'(v.exp_err));
    if (v.exp_err) begin
      chk({nm, "_reqs"}, 64'(req_log.size()), 0);
      chk({nm, "_issues"}, 64'(iw_log.size()), 0);
    end else begin
      for (int i = 0; i < iw_log.size(); i++)
        if (iw_log[i] == v.warp && im_log[i] == v.mask &&
            ii_log[i] == ((v.addr + 32'(4 * i)) ^ K)) ok++;
      chk({nm, "_reqs"}, 64'(req_log.size()), 64'(v.len));
      chk({nm, "_first"}, req_log.size() > 0 ? req_log[0] : 0, v.addr);
      chk({nm, "_last"}, req_log.size() > 0 ? req_log[$] : 0, v.exp_last);
      chk({nm, "_data"}, 64'(ok), 64'(v.len));
      chk({nm, "_done"}, done_log.size() == 1 ? 64'(done_log[0]) : 64'hEE,
          64'(v.warp));
    end
    chk({nm, "_busy"}, 64'(warp_busy), 0);
  endtask

  initial begin
    int cyc;
    int ok;
    vecs[0] = '{2'd0, 32'h0000_1000, 16'd3, 8'hFF, 1'b0, 32'h0000_1008};
    vecs[1] = '{2'd3, 32'h0000_2000, 16'd1, 8'h0F, 1'b0, 32'h0000_2000};
    vecs[2] = '{2'd1, 32'h0000_3000, 16'd0, 8'hFF, 1'b1, 32'h0};
    vecs[3] = '{2'd2, 32'h0000_0FF0, 16'd6, 8'hA5, 1'b0, 32'h0000_1004};
    vecs[4] = '{2'd3, 32'hFFFF_FFF8, 16'd2, 8'h01, 1'b0, 32'hFFFF_FFFC};

    rst = 1'b1;
    launch_valid = 1'b0;
    launch_warp = '0;
    launch_addr = '0;
    launch_len = '0;
    launch_mask = '0;
    mem_req_ready = 1'b1;
    issue_ready = 1'b0;
    repeat (3) tick();
    chk("rst_req_valid", 64'(mem_req_valid), 0);
    chk("rst_issue_valid", 64'(issue_valid), 0);
    chk("rst_launch_ready", 64'(launch_ready), 0);
    chk("rst_busy", 64'(warp_busy), 0);
    chk("rst_done", 64'(done_valid), 0);
    chk("rst_err", 64'(launch_error), 0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", 64'(launch_ready), 1);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Two warps filled while issue is stalled, then drained alternately
    clear_logs();
    issue_ready = 1'b0;
    do_launch(2'd0, 32'h100, 16'd4, 8'h11);
    do_launch(2'd1, 32'h200, 16'd4, 8'h22);
    repeat (20) tick();
    chk("alt_busy", 64'(warp_busy), 64'h3);
    issue_ready = 1'b1;
    wait_done(2, "alt");
    ok = 0;
    for (int i = 0; i < iw_log.size(); i++)
      if (iw_log[i] == 2'(i % 2) &&
          ii_log[i] == (((i % 2) ? 32'h200 : 32'h100) + 32'(4 * (i / 2))) ^ K)
        ok++;
    chk("alt_count", 64'(iw_log.size()), 8);
    chk("alt_order", 64'(ok), 8);
    chk("alt_done0", done_log.size() == 2 ? 64'(done_log[0]) : 64'hEE, 0);
    chk("alt_done1", done_log.size() == 2 ? 64'(done_log[1]) : 64'hEE, 1);

    // Credit limit with issue stalled
    clear_logs();
    issue_ready = 1'b0;
    do_launch(2'd2, 32'h4000, 16'd10, 8'hF0);
    repeat (30) tick();
    chk("credit_reqs", 64'(req_log.size()), 4);
    chk("credit_hold_warp", 64'(issue_warp), 2);
    chk("credit_hold_instr", 64'(issue_instr), 64'(32'h4000 ^ K));
    issue_ready = 1'b1;
    wait_done(1, "credit");
    ok = 0;
    for (int i = 0; i < ii_log.size(); i++)
      if (ii_log[i] == ((32'h4000 + 32'(4 * i)) ^ K) && im_log[i] == 8'hF0)
        ok++;
    chk("credit_total_reqs", 64'(req_log.size()), 10);
    chk("credit_data", 64'(ok), 10);

    // Busy-warp and zero-length launches are rejected
    clear_logs();
    issue_ready = 1'b1;
    do_launch(2'd2, 32'h5000, 16'd8, 8'h3C);
    do_launch(2'd2, 32'h9000, 16'd3, 8'hFF);
    do_launch(2'd0, 32'h9100, 16'd0, 8'hFF);
    wait_done(1, "err");
    ok = 0;
    for (int i = 0; i < ii_log.size(); i++)
      if (iw_log[i] == 2'd2 && ii_log[i] == ((32'h5000 + 32'(4 * i)) ^ K))
        ok++;
    chk("err_pulses", 64'(err_cnt), 2);
    chk("err_w2_data", 64'(ok), 8);
    chk("err_w2_last", req_log.size() > 0 ? req_log[$] : 0, 32'h501C);
    chk("err_done", done_log.size() == 1 ? 64'(done_log[0]) : 64'hEE, 2);

    // All warps busy: launch_ready drops and a pending launch waits
    clear_logs();
    issue_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      do_launch(2'(i), 32'hA000 + 32'(i * 256), 16'd2, 8'hFF);
    chk("full_ready", 64'(launch_ready), 0);
    chk("full_busy", 64'(warp_busy), 64'hF);
    launch_valid = 1'b1;
    launch_len = 16'd1;
    tick();
    tick();
    launch_valid = 1'b0;
    chk("full_no_err", 64'(err_cnt), 0);
    issue_ready = 1'b1;
    wait_done(4, "full");
    chk("full_issues", 64'(iw_log.size()), 8);
    chk("full_idle", 64'(warp_busy), 0);

    // Relaunch on the cycle right after the done pulse
    clear_logs();
    do_launch(2'd3, 32'hB000, 16'd1, 8'h77);
    cyc = 0;
    while (!done_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("relaunch_timeout", 64'(cyc >= 100), 0);
    tick();
    chk("relaunch_ready", 64'(launch_ready), 1);
    do_launch(2'd3, 32'hB100, 16'd1, 8'h77);
    wait_done(2, "relaunch");
    chk("relaunch_err", 64'(err_cnt), 0);
    chk("relaunch_data", ii_log.size() == 2 ? ii_log[1] : 0, 32'hB100 ^ K);

    // Reset mid-fetch with two responses outstanding
    clear_logs();
    mem_hold = 1'b1;
    issue_ready = 1'b1;
    do_launch(2'd1, 32'h6000, 16'd6, 8'hFF);
    cyc = 0;
    while (req_log.size() < 2 && cyc < 50) begin
      tick();
      cyc++;
    end
    mem_req_ready = 1'b0;
    chk("mid_timeout", 64'(cyc >= 50), 0);
    tick();
    tick();
    chk("mid_req_held", 64'(mem_req_valid), 1);
    chk("mid_req_addr", 64'(mem_req_addr), 32'h6008);
    rst = 1'b1;
    #1;
    chk("mid_rst_req", 64'(mem_req_valid), 0);
    chk("mid_rst_ready", 64'(launch_ready), 0);
    chk("mid_rst_busy", 64'(warp_busy), 0);
    tick();
    tick();
    rst = 1'b0;
    mem_hold = 1'b0;
    mem_req_ready = 1'b1;
    repeat (8) tick();
    chk("late_issues", 64'(iw_log.size()), 0);
    chk("late_issue_valid", 64'(issue_valid), 0);
    chk("late_busy", 64'(warp_busy), 0);
    chk("late_req_valid", 64'(mem_req_valid), 0);
    run_vec('{2'd1, 32'h7000, 16'd2, 8'hFF, 1'b0, 32'h7004}, "fresh");

`ifdef WARP_DISPATCH_STATS_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    clear_logs();
    issue_ready = 1'b0;
    do_launch(2'd0, 32'h8000, 16'd5, 8'hFF);
    cyc = 0;
    while (!issue_valid && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("stat_timeout", 64'(cyc >= 50), 0);
    repeat (3) tick();
    issue_ready = 1'b1;
    wait_done(1, "stat");
    chk("stat_issued", 64'(stat_issued), 5);
    chk("stat_stall", 64'(stat_stall), 3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
